// File: rtl/postalu.sv
// ============================================================================
// Module   : postalu
// Purpose  : ALU adder-hold stage with optional one-cycle BCD correction and
//            SB/ADL bus read-back.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module postalu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cout,
    input  logic             alu_vout,
    input  logic             alu_hc,
    input  logic             ld,
    input  logic             dec_en,
    input  logic             sub,
    input  logic             sbre,
    input  logic             adlre,
    output logic [WIDTH-1:0] sbout,
    output logic             sbdrv,
    output logic [WIDTH-1:0] adlout,
    output logic             adldrv,
    output logic             cout,
    output logic             vout,
    output logic             valid,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADJ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [WIDTH-1:0] C_ADJ_LO = WIDTH'(8'h06);
    localparam logic [WIDTH-1:0] C_ADJ_HI = WIDTH'(8'h60);
    localparam logic [WIDTH-1:0] C_BCD_MAX = WIDTH'(8'h99);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_cout;
    logic             r_vout;
    logic             r_hc;
    logic             r_sub;

    logic             w_lo;
    logic             w_hi;
    logic [WIDTH-1:0] w_add_res;
    logic [WIDTH-1:0] w_sub_res;
    logic [WIDTH-1:0] w_corr_res;
    logic             w_corr_cout;

    // While in ADJ, r_hold/r_cout carry the raw latched result and carry.
    always_comb begin
        w_lo        = r_hc | (r_hold[3:0] > 4'd9);
        w_hi        = r_cout | (r_hold > C_BCD_MAX);
        w_add_res   = r_hold + (w_lo ? C_ADJ_LO : '0) + (w_hi ? C_ADJ_HI : '0);
        w_sub_res   = r_hold - (r_hc ? '0 : C_ADJ_LO) - (r_cout ? '0 : C_ADJ_HI);
        w_corr_res  = r_sub ? w_sub_res : w_add_res;
        w_corr_cout = r_sub ? r_cout : (r_cout | w_hi);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_cout  <= 1'b0;
            r_vout  <= 1'b0;
            r_hc    <= 1'b0;
            r_sub   <= 1'b0;
        end else if (ld) begin
            r_state <= dec_en ? S_ADJ : S_HOLD;
            r_hold  <= alu_res;
            r_cout  <= alu_cout;
            r_vout  <= alu_vout;
            r_hc    <= alu_hc;
            r_sub   <= sub;
        end else if (r_state == S_ADJ) begin
            r_state <= S_HOLD;
            r_hold  <= w_corr_res;
            r_cout  <= w_corr_cout;
        end
    end

    always_comb begin
        valid  = (r_state == S_HOLD);
        busy   = (r_state == S_ADJ);
        cout   = r_cout;
        vout   = r_vout;
        sbdrv  = sbre & valid;
        adldrv = adlre & valid;
        sbout  = sbdrv ? r_hold : '0;
        adlout = adldrv ? r_hold : '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_postalu.sv
// ============================================================================
// Module   : tb_postalu
// Purpose  : Directed self-checking bench for postalu.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_postalu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] alu_res = '0;
    logic       alu_cout = 1'b0;
    logic       alu_vout = 1'b0;
    logic       alu_hc = 1'b0;
    logic       ld = 1'b0;
    logic       dec_en = 1'b0;
    logic       sub = 1'b0;
    logic       sbre = 1'b0;
    logic       adlre = 1'b0;
    logic [7:0] sbout;
    logic       sbdrv;
    logic [7:0] adlout;
    logic       adldrv;
    logic       cout;
    logic       vout;
    logic       valid;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    postalu #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .alu_res(alu_res), .alu_cout(alu_cout), .alu_vout(alu_vout), .alu_hc(alu_hc),
        .ld(ld), .dec_en(dec_en), .sub(sub), .sbre(sbre), .adlre(adlre),
        .sbout(sbout), .sbdrv(sbdrv), .adlout(adlout), .adldrv(adldrv),
        .cout(cout), .vout(vout), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] res, input logic c, input logic v,
                        input logic h, input logic d, input logic s);
        alu_res = res; alu_cout = c; alu_vout = v; alu_hc = h;
        dec_en = d; sub = s; ld = 1'b1;
        tick();
        ld = 1'b0; dec_en = 1'b0; sub = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cout", cout, 0);
        chk("rst_vout", vout, 0);
        chk("rst_sbdrv", sbdrv, 0);
        chk("rst_adldrv", adldrv, 0);
        reset = 1'b0;
        tick();

        // Read while IDLE
        sbre = 1'b1;
        #1;
        chk("idle_sbdrv", sbdrv, 0);
        chk("idle_sbout", sbout, 8'h00);

        // Binary load 3C
        load(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bin_valid", valid, 1);
        chk("bin_sbdrv", sbdrv, 1);
        chk("bin_sbout", sbout, 8'h3C);
        chk("bin_adldrv", adldrv, 0);
        chk("bin_adlout", adlout, 8'h00);
        chk("bin_cout", cout, 1);
        tick();
        chk("bin_reread", sbout, 8'h3C);

        // Decimal add 09+08 -> 17
        sbre = 1'b1; adlre = 1'b1;
        load(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("dadd1_busy", busy, 1);
        chk("dadd1_valid", valid, 0);
        chk("adj_sbdrv", sbdrv, 0);
        chk("adj_sbout", sbout, 8'h00);
        chk("adj_adlout", adlout, 8'h00);
        tick();
        chk("dadd1_busy2", busy, 0);
        chk("dadd1_valid2", valid, 1);
        chk("dadd1_adlout", adlout, 8'h17);
        chk("dadd1_cout", cout, 0);

        // Decimal add 45+55 -> 00 carry, overflow kept
        load(8'h9A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("dadd2_sbout", sbout, 8'h00);
        chk("dadd2_adlout", adlout, 8'h00);
        chk("dadd2_sbdrv", sbdrv, 1);
        chk("dadd2_adldrv", adldrv, 1);
        chk("dadd2_cout", cout, 1);
        chk("dadd2_vout", vout, 1);

        // Decimal sub 10-01 -> 09
        load(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("dsub1_hold", adlout, 8'h09);
        chk("dsub1_cout", cout, 1);
        chk("dsub1_vout", vout, 0);

        // Decimal sub with high borrow -> 90
        load(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("dsub2_hold", sbout, 8'h90);
        chk("dsub2_cout", cout, 0);

        // Reset during ADJ
        load(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("preabort_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_sbdrv", sbdrv, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_idle_valid", valid, 0);
        chk("abort_idle_sbout", sbout, 8'h00);

        // ld binary during ADJ discards the correction
        load(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        load(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_valid", valid, 1);
        chk("restart_sbout", sbout, 8'h55);
        chk("restart_vout", vout, 1);
        tick();
        chk("restart_keep", sbout, 8'h55);

        // ld with read in the same cycle returns the old value before the edge
        alu_res = 8'h22; dec_en = 1'b1; ld = 1'b1;
        #1;
        chk("ldread_old", sbout, 8'h55);
        tick();
        ld = 1'b0; dec_en = 1'b0;
        chk("ldread_sbdrv", sbdrv, 0);
        chk("ldread_busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/postalu.md
Name: postalu

Overview:
- Adder-hold stage that sits behind the ALU. It is the return path of the pre-ALU input registers.
- Captures an ALU result and its flags, and optionally applies a one-cycle BCD decimal correction.
- Holds the final value and drives it back onto the SB and/or ADL internal buses on request.
- The datapath control logic uses valid/busy to sequence bus transfers.

Parameters:
- WIDTH, 8, data width of the result and of both buses. The BCD logic is defined only for 8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_res  in  WIDTH  raw binary ALU result.
- alu_cout  in  1  ALU carry out (for subtract, 1 = no borrow).
- alu_vout  in  1  ALU overflow.
- alu_hc  in  1  ALU half-carry out of bit 3 (for subtract, 1 = no borrow).
- ld  in  1  capture alu_* this cycle.
- dec_en  in  1  sampled with ld; request decimal correction.
- sub  in  1  sampled with ld; the operation was a subtract.
- sbre  in  1  drive the held value onto SB.
- adlre  in  1  drive the held value onto ADL.
- sbout  out  WIDTH  SB drive data.
- sbdrv  out  1  SB drive enable.
- adlout  out  WIDTH  ADL drive data.
- adldrv  out  1  ADL drive enable.
- cout  out  1  final carry.
- vout  out  1  held overflow.
- valid  out  1  the held value is final and readable.
- busy  out  1  decimal correction in progress.

Behaviour:
- Reset (asynchronous): state=IDLE, hold=0, cout=0, vout=0, valid=0, busy=0. Drive enables go to 0 immediately.
- Reset asserted mid-ADJ aborts the correction; no partial value survives.

- States:
  - IDLE: no result held.
  - ADJ: one-cycle BCD correction.
  - HOLD: result final.

- Transitions (ld has priority from every state, including ADJ):
  - ld with dec_en=0 -> HOLD. hold=alu_res, cout=alu_cout, vout=alu_vout.
  - ld with dec_en=1 -> ADJ. Latch alu_res, alu_cout, alu_hc, alu_vout and sub.
  - ld during ADJ discards the pending correction and restarts from the new inputs.
  - ADJ -> HOLD after exactly 1 cycle with the corrected value.
  - HOLD stays in HOLD until the next ld. Reads do not consume the value; it may be read any number of times.

- Latency:
  - Binary: valid=1 in the cycle after the ld edge.
  - Decimal: busy=1 for one cycle, then valid=1 (2 cycles after the ld edge).
  - valid=1 only in HOLD; busy=1 only in ADJ.

- Decimal correction (r, c, h are the latched result, carry and half-carry):
  - Add, low nibble: lo = (h=1 or r[3:0]>9).
  - Add, high nibble: hi = (c=1 or r>8'h99).
  - Add, result: r + (lo?8'h06:0) + (hi?8'h60:0), modulo 256. cout = c | hi.
  - Sub: r - (h=0 ? 8'h06 : 0) - (c=0 ? 8'h60 : 0), modulo 256. cout = c (unchanged).
  - vout keeps the latched binary overflow in both cases.

- Bus drive (combinational from state and read enables):
  - sbdrv = sbre & valid; sbout = sbdrv ? hold : 0.
  - adldrv = adlre & valid; adlout = adldrv ? hold : 0.
  - sbre and adlre together drive both buses with the same value.
  - A read while IDLE or ADJ gives drv=0 and data 0; the value is not stalled or queued.
  - ld and a read in the same cycle: the read returns the old hold if valid was 1 before the edge. After the edge valid follows the new state.

Test Plan:
- Reset -> all outputs 0. Then ld with alu_res=8'h3C, dec_en=0, sbre=1 held -> next cycle valid=1, sbdrv=1, sbout=3C, adldrv=0.
- Decimal add 09+08: ld with res=11, hc=1, c=0 -> busy=1 for 1 cycle, then hold=17, cout=0. With adlre=1, adlout=17.
- Decimal add 45+55: ld with res=9A, hc=0, c=0 -> hold=00, cout=1. With sbre and adlre both set, both buses carry 00.
- Decimal sub 10-01: ld with res=0F, sub=1, hc=0, c=1 -> hold=09, cout=1. Second case: res=F0, hc=1, c=0 -> hold=90, cout=0.
- Read while not valid: sbre=1 in IDLE and in ADJ -> sbdrv=0, sbout=00.
- Reset during ADJ -> IDLE, hold=0. Separately, ld (binary, res=55) during ADJ -> next cycle HOLD with hold=55 and the correction discarded.
